// File: rtl/key_step_sequencer_pkg.sv
// Shared types and default timing for the key step sequencer.
package key_step_sequencer_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  // Direction owned by HOLD/REPEAT
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Defaults for a 50 MHz system clock
  localparam int DEF_WIDTH        = 4;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms
  localparam int DEF_HOLD_CYC     = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CYC   = 12_500_000;  // 250 ms

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_step_sequencer_key_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low key.
// pressed is the debounced level; press_evt/release_evt pulse for one cycle
// in the first cycle the debounced level shows the change.
module key_debounce
  import key_step_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic FPGA_CLK,
  input  logic RESET_BUT,
  input  logic key_n,
  output logic pressed,
  output logic press_evt,
  output logic release_evt
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             pressed_q, pressed_d;
  logic             press_evt_q, press_evt_d;
  logic             release_evt_q, release_evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the raw key into the clock domain
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      // NOTE: synchronizers reset to the released level, so a key held through reset must debounce afresh.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, giving a true 2-stage chain.
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synced level disagrees with the accepted level
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    cnt_d         = '0;
    pressed_d     = pressed_q;
    press_evt_d   = 1'b0;
    release_evt_d = 1'b0;
    if (~sync2_q != pressed_q) begin
      if (cnt_q == CNT_LAST) begin
        pressed_d     = ~sync2_q;
        press_evt_d   = ~sync2_q;
        release_evt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      cnt_q         <= '0;
      pressed_q     <= 1'b0;
      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pressed_q     <= pressed_d;
      press_evt_q   <= press_evt_d;
      release_evt_q <= release_evt_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_evt   = press_evt_q;
  assign release_evt = release_evt_q;

endmodule

// File: rtl/key_step_sequencer.sv
// Key step sequencer: debounces UP/DOWN keys, arbitrates them into single
// step commands with hold-to-auto-repeat, and owns the LED counter register.
module key_step_sequencer
  import key_step_sequencer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit WRAP         = 1'b1
) (
  input  logic             FPGA_CLK,
  input  logic             RESET_BUT,
  input  logic             KEY_UP_N,
  input  logic             KEY_DN_N,
  output logic [WIDTH-1:0] value,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             active
);

  // Shared hold/repeat timer; REPEAT_CYC is expected not to exceed HOLD_CYC
  localparam int TMR_W = cnt_width(HOLD_CYC);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYC - 1);
  localparam logic [WIDTH-1:0] VAL_MAX     = '1;

  logic up_pressed, up_press_evt, up_release_evt;
  logic dn_pressed, dn_press_evt, dn_release_evt;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;

  logic step_req;
  dir_e step_dir;
  logic dir_released;
  logic other_held;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_up (
    .FPGA_CLK   (FPGA_CLK),
    .RESET_BUT  (RESET_BUT),
    .key_n      (KEY_UP_N),
    .pressed    (up_pressed),
    .press_evt  (up_press_evt),
    .release_evt(up_release_evt)
  );

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_dn (
    .FPGA_CLK   (FPGA_CLK),
    .RESET_BUT  (RESET_BUT),
    .key_n      (KEY_DN_N),
    .pressed    (dn_pressed),
    .press_evt  (dn_press_evt),
    .release_evt(dn_release_evt)
  );

  // The owning key can only be released while it is held, so its release
  // event marks the end of a HOLD/REPEAT run.
  assign dir_released = (dir_q == DIR_UP) ? up_release_evt : dn_release_evt;
  assign other_held   = (dir_q == DIR_UP) ? dn_pressed : up_pressed;

  // Next-state, direction, timer and step request
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    timer_d  = timer_q + 1'b1;
    step_req = 1'b0;
    step_dir = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if ((up_press_evt || dn_press_evt) && up_pressed && dn_pressed) begin
          state_d = ST_LOCK;
        end else if (up_press_evt) begin
          state_d  = ST_HOLD;
          dir_d    = DIR_UP;
          step_req = 1'b1;
          step_dir = DIR_UP;
        end else if (dn_press_evt) begin
          state_d  = ST_HOLD;
          dir_d    = DIR_DN;
          step_req = 1'b1;
          step_dir = DIR_DN;
        end
      end
      ST_HOLD: begin
        if (dir_released) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (other_held) begin
          state_d = ST_LOCK;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d  = ST_REPEAT;
          timer_d  = '0;
          step_req = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (dir_released) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (other_held) begin
          state_d = ST_LOCK;
          timer_d = '0;
        end else if (timer_q == REPEAT_LAST) begin
          timer_d  = '0;
          step_req = 1'b1;
        end
      end
      ST_LOCK: begin
        timer_d = '0;
        if (!up_pressed && !dn_pressed) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Counter arithmetic; at a saturation limit the strobe still fires
  always_comb begin
    value_d = value_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    if (step_req) begin
      if (step_dir == DIR_UP) begin
        inc_d = 1'b1;
        if (WRAP || (value_q != VAL_MAX)) begin
          value_d = value_q + 1'b1;
        end
      end else begin
        dec_d = 1'b1;
        if (WRAP || (value_q != '0)) begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  // Controller and counter registers
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      timer_q <= '0;
      value_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      value_q <= value_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign value     = value_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign active    = (state_q != ST_IDLE);

endmodule
